// File: rtl/text_ram_scheduler_pkg.sv
// text_ram_scheduler_pkg: shared text-display constants, state and grant encodings
package text_ram_scheduler_pkg;
  localparam int unsigned ROWS = 32;
  localparam int unsigned COLS = 70;
  localparam int unsigned DEPTH = 2240;
  localparam int unsigned ADDR_W = 12;
  localparam logic [7:0] BLANK = 8'h20;
  typedef enum logic {IDLE, SWEEP} state_t;
  typedef enum logic {GRANT_KB, GRANT_OUT} grant_t;
endpackage

// File: rtl/text_ram_scheduler_if.sv
// text_ram_scheduler_if: requester handshakes, sweep control and text RAM write port
interface text_ram_scheduler_if;
  import text_ram_scheduler_pkg::*;
  logic cls_start, kb_req, kb_ack, out_req, out_ack, ram_wren, busy, cls_done, drop_err;
  logic [7:0] kb_ascii, kb_y, out_ascii, out_y, ram_data;
  logic [5:0] kb_x, out_x;
  logic [ADDR_W-1:0] ram_addr;
  modport master (
    output cls_start, kb_req, kb_ascii, kb_x, kb_y, out_req, out_ascii, out_x, out_y,
    input kb_ack, out_ack, ram_addr, ram_data, ram_wren, busy, cls_done, drop_err
  );
  modport slave (
    input cls_start, kb_req, kb_ascii, kb_x, kb_y, out_req, out_ascii, out_x, out_y,
    output kb_ack, out_ack, ram_addr, ram_data, ram_wren, busy, cls_done, drop_err
  );
endinterface

// File: rtl/text_ram_scheduler_addr_calc.sv
// text_addr_calc: row/column to linear text RAM address (x*70+y) with range check
module text_addr_calc
  import text_ram_scheduler_pkg::*;
(
  input  logic [5:0]        x,
  input  logic [7:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              in_range
);
  always_comb begin
    addr = {x, 6'b0} + {4'b0, x, 2'b0} + {5'b0, x, 1'b0} + {4'b0, y};
    in_range = (x < 6'(ROWS)) && (y < 8'(COLS));
  end
endmodule

// File: rtl/text_ram_scheduler.sv
// text_ram_scheduler: round-robin text RAM write arbiter with full-screen blank sweep
module text_ram_scheduler
  import text_ram_scheduler_pkg::*;
(
  input logic                  clk,
  input logic                  clear,
  text_ram_scheduler_if.slave  bus
);
  state_t state;
  grant_t last_grant;
  logic [ADDR_W-1:0] cnt, calc_addr;
  logic kb_elig, out_elig, grant_kb, grant_out, in_range;
  logic [7:0] g_ascii, g_y;
  logic [5:0] g_x;
  always_comb begin
    kb_elig = bus.kb_req && !bus.kb_ack;
    out_elig = bus.out_req && !bus.out_ack;
    grant_kb = kb_elig && (!out_elig || last_grant == GRANT_OUT);
    grant_out = out_elig && !grant_kb;
    g_ascii = grant_kb ? bus.kb_ascii : bus.out_ascii;
    g_x = grant_kb ? bus.kb_x : bus.out_x;
    g_y = grant_kb ? bus.kb_y : bus.out_y;
  end
  text_addr_calc u_addr_calc (
    .x        (g_x),
    .y        (g_y),
    .addr     (calc_addr),
    .in_range (in_range)
  );
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= GRANT_OUT;
      bus.ram_addr <= '0;
      bus.ram_data <= '0;
      bus.ram_wren <= 1'b0;
      bus.kb_ack <= 1'b0;
      bus.out_ack <= 1'b0;
      bus.busy <= 1'b0;
      bus.cls_done <= 1'b0;
      bus.drop_err <= 1'b0;
    end else begin
      bus.kb_ack <= 1'b0;
      bus.out_ack <= 1'b0;
      bus.ram_wren <= 1'b0;
      bus.cls_done <= 1'b0;
      if (state == SWEEP) begin
        bus.ram_addr <= cnt;
        bus.ram_data <= BLANK;
        bus.ram_wren <= 1'b1;
        cnt <= cnt + 12'd1;
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state <= IDLE;
          cnt <= '0;
          bus.busy <= 1'b0;
          bus.cls_done <= 1'b1;
        end
      end else if (bus.cls_start) begin
        state <= SWEEP;
        cnt <= '0;
        bus.busy <= 1'b1;
      end else if (grant_kb || grant_out) begin
        bus.kb_ack <= grant_kb;
        bus.out_ack <= grant_out;
        last_grant <= grant_kb ? GRANT_KB : GRANT_OUT;
        if (!in_range) bus.drop_err <= 1'b1;
        else if (g_ascii != 8'h00) begin
          bus.ram_addr <= calc_addr;
          bus.ram_data <= g_ascii;
          bus.ram_wren <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_text_ram_scheduler.sv
// tb_text_ram_scheduler: directed and randomized self-checking bench for text_ram_scheduler
module tb_text_ram_scheduler;
  logic clk = 1'b0;
  logic clear;
  int checks = 0;
  int errors = 0;
  text_ram_scheduler_if bus();
  text_ram_scheduler dut (.clk(clk), .clear(clear), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(int x, int y);
    return x < 32 && y < 70;
  endfunction

  task automatic idle_inputs();
    bus.cls_start = 0;
    bus.kb_req = 0;
    bus.kb_ascii = 0;
    bus.kb_x = 0;
    bus.kb_y = 0;
    bus.out_req = 0;
    bus.out_ascii = 0;
    bus.out_x = 0;
    bus.out_y = 0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    clear = 1;
    tick();
    tick();
    checks++;
    if ({bus.ram_addr, bus.ram_data, bus.ram_wren, bus.kb_ack, bus.out_ack, bus.busy, bus.cls_done, bus.drop_err} !== '0) begin
      errors++;
      $display("FAIL reset: addr=%0d data=%h wren=%b kb_ack=%b out_ack=%b busy=%b done=%b drop=%b, want all zero",
               bus.ram_addr, bus.ram_data, bus.ram_wren, bus.kb_ack, bus.out_ack, bus.busy, bus.cls_done, bus.drop_err);
    end
    clear = 0;
  endtask

  task automatic test_single_write();
    do_clear();
    bus.kb_req = 1; bus.kb_ascii = 8'h41; bus.kb_x = 2; bus.kb_y = 10;
    tick();
    checks++;
    if (bus.kb_ack !== 1 || bus.out_ack !== 0 || bus.ram_wren !== 1 || bus.ram_addr !== 12'd150 || bus.ram_data !== 8'h41) begin
      errors++;
      $display("FAIL single_write: kb_ack=%b out_ack=%b wren=%b addr=%0d data=%h, want 1 0 1 150 41",
               bus.kb_ack, bus.out_ack, bus.ram_wren, bus.ram_addr, bus.ram_data);
    end
    bus.kb_req = 0;
    tick();
    checks++;
    if (bus.kb_ack !== 0 || bus.ram_wren !== 0 || bus.ram_addr !== 12'd150 || bus.ram_data !== 8'h41) begin
      errors++;
      $display("FAIL single_hold: kb_ack=%b wren=%b addr=%0d data=%h, want 0 0 150 41",
               bus.kb_ack, bus.ram_wren, bus.ram_addr, bus.ram_data);
    end
  endtask

  task automatic test_null_char();
    do_clear();
    bus.kb_req = 1; bus.kb_ascii = 8'h00; bus.kb_x = 3; bus.kb_y = 5;
    tick();
    checks++;
    if (bus.kb_ack !== 1 || bus.ram_wren !== 0 || bus.drop_err !== 0 || bus.ram_addr !== 12'd0) begin
      errors++;
      $display("FAIL null_char: kb_ack=%b wren=%b drop=%b addr=%0d, want 1 0 0 0",
               bus.kb_ack, bus.ram_wren, bus.drop_err, bus.ram_addr);
    end
    bus.kb_req = 0;
    tick();
  endtask

  task automatic test_drop();
    bus.out_req = 1; bus.out_ascii = 8'h5a; bus.out_x = 31; bus.out_y = 70;
    tick();
    checks++;
    if (bus.out_ack !== 1 || bus.ram_wren !== 0 || bus.drop_err !== 1) begin
      errors++;
      $display("FAIL drop_out_of_range: out_ack=%b wren=%b drop=%b, want 1 0 1", bus.out_ack, bus.ram_wren, bus.drop_err);
    end
    bus.out_req = 0;
    tick();
    checks++;
    if (bus.drop_err !== 1 || bus.out_ack !== 0) begin
      errors++;
      $display("FAIL drop_sticky: drop=%b out_ack=%b, want 1 0", bus.drop_err, bus.out_ack);
    end
    bus.kb_req = 1; bus.kb_ascii = 8'h71; bus.kb_x = 31; bus.kb_y = 69;
    tick();
    checks++;
    if (bus.kb_ack !== 1 || bus.ram_wren !== 1 || bus.ram_addr !== 12'd2239 || bus.ram_data !== 8'h71 || bus.drop_err !== 1) begin
      errors++;
      $display("FAIL drop_after_valid: ack=%b wren=%b addr=%0d data=%h drop=%b, want 1 1 2239 71 1",
               bus.kb_ack, bus.ram_wren, bus.ram_addr, bus.ram_data, bus.drop_err);
    end
    bus.kb_req = 0;
    tick();
  endtask

  task automatic test_round_robin();
    do_clear();
    bus.kb_req = 1; bus.kb_ascii = 8'h6b; bus.kb_x = 1; bus.kb_y = 1;
    bus.out_req = 1; bus.out_ascii = 8'h6f; bus.out_x = 0; bus.out_y = 5;
    for (int i = 0; i < 8; i++) begin
      bit want_kb;
      want_kb = (i % 2 == 0);
      tick();
      checks++;
      if (bus.kb_ack !== want_kb || bus.out_ack !== !want_kb || bus.ram_wren !== 1 ||
          bus.ram_data !== (want_kb ? 8'h6b : 8'h6f) || bus.ram_addr !== (want_kb ? 12'd71 : 12'd5)) begin
        errors++;
        $display("FAIL round_robin[%0d]: kb_ack=%b out_ack=%b wren=%b addr=%0d data=%h, want kb_ack=%b",
                 i, bus.kb_ack, bus.out_ack, bus.ram_wren, bus.ram_addr, bus.ram_data, want_kb);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit pend[2];
    int age[2], rx[2], ry[2];
    logic [7:0] ra[2];
    bit exp_drop, exp_wren;
    logic [11:0] exp_a;
    logic [7:0] exp_d;
    do_clear();
    exp_drop = 0; exp_a = 0; exp_d = 0;
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 400; c++) begin
      int r;
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1;
          age[k] = 0;
          ra[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
          rx[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 31);
          ry[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(70, 255) : $urandom_range(0, 69);
        end
      end
      bus.kb_req = pend[0]; bus.kb_ascii = ra[0]; bus.kb_x = 6'(rx[0]); bus.kb_y = 8'(ry[0]);
      bus.out_req = pend[1]; bus.out_ascii = ra[1]; bus.out_x = 6'(rx[1]); bus.out_y = 8'(ry[1]);
      tick();
      r = bus.kb_ack ? 0 : (bus.out_ack ? 1 : -1);
      checks++;
      if ((bus.kb_ack && bus.out_ack) || (r >= 0 && !pend[r])) begin
        errors++;
        $display("FAIL rand_ack[%0d]: kb_ack=%b out_ack=%b pend=%b%b", c, bus.kb_ack, bus.out_ack, pend[0], pend[1]);
      end
      exp_wren = 0;
      if (r >= 0 && pend[r]) begin
        exp_wren = in_rng(rx[r], ry[r]) && ra[r] != 8'h00;
        if (!in_rng(rx[r], ry[r])) exp_drop = 1;
        if (exp_wren) begin
          exp_a = 12'(rx[r] * 70 + ry[r]);
          exp_d = ra[r];
        end
        pend[r] = 0;
      end
      checks++;
      if (bus.ram_wren !== exp_wren || bus.ram_addr !== exp_a || bus.ram_data !== exp_d || bus.drop_err !== exp_drop) begin
        errors++;
        $display("FAIL rand_write[%0d]: wren=%b addr=%0d data=%h drop=%b, want %b %0d %h %b",
                 c, bus.ram_wren, bus.ram_addr, bus.ram_data, bus.drop_err, exp_wren, exp_a, exp_d, exp_drop);
      end
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          age[k]++;
          checks++;
          if (age[k] > 4) begin
            errors++;
            $display("FAIL rand_starve[%0d]: requester %0d waiting %0d cycles, want <= 4", c, k, age[k]);
            pend[k] = 0;
          end
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_sweep();
    int busy_cnt, next, bad, early_ack;
    bit done, acked;
    do_clear();
    bus.cls_start = 1;
    tick();
    bus.cls_start = 0;
    busy_cnt = bus.busy ? 1 : 0;
    next = 0; bad = 0; early_ack = 0; done = 0;
    for (int c = 0; c < 2400 && !done; c++) begin
      if (c == 500) begin
        bus.kb_req = 1; bus.kb_ascii = 8'h53; bus.kb_x = 5; bus.kb_y = 7;
      end
      bus.cls_start = (c == 700);
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.kb_ack || bus.out_ack) early_ack++;
      if (bus.ram_wren) begin
        if (bus.ram_addr !== 12'(next) || bus.ram_data !== 8'h20) bad++;
        next++;
      end
      if (bus.cls_done) begin
        done = 1;
        checks++;
        if (next != 2240 || bus.ram_wren !== 1 || bus.busy !== 0) begin
          errors++;
          $display("FAIL sweep_done: writes=%0d wren=%b busy=%b at cls_done, want 2240 1 0", next, bus.ram_wren, bus.busy);
        end
      end
    end
    bus.cls_start = 0;
    checks++;
    if (!done || busy_cnt != 2240 || bad != 0 || next != 2240 || early_ack != 0) begin
      errors++;
      $display("FAIL sweep: done=%b busy_cycles=%0d bad_writes=%0d writes=%0d acks_in_sweep=%0d, want 1 2240 0 2240 0",
               done, busy_cnt, bad, next, early_ack);
    end
    acked = 0;
    for (int c = 0; c < 5 && !acked; c++) begin
      tick();
      if (bus.kb_ack) begin
        acked = 1;
        checks++;
        if (bus.ram_wren !== 1 || bus.ram_addr !== 12'd357 || bus.ram_data !== 8'h53 || bus.cls_done !== 0 || bus.busy !== 0) begin
          errors++;
          $display("FAIL sweep_stalled_kb: wren=%b addr=%0d data=%h done=%b busy=%b, want 1 357 53 0 0",
                   bus.ram_wren, bus.ram_addr, bus.ram_data, bus.cls_done, bus.busy);
        end
      end
    end
    checks++;
    if (!acked) begin
      errors++;
      $display("FAIL sweep_kb_timeout: kb_ack=0 after sweep, want 1 within 5 cycles");
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_clear_mid_sweep();
    bit found;
    int bad;
    do_clear();
    bus.cls_start = 1;
    tick();
    bus.cls_start = 0;
    found = 0;
    for (int c = 0; c < 1200 && !found; c++) begin
      tick();
      if (bus.ram_wren && bus.ram_addr == 12'd1000) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL clear_mid_find: address 1000 not written, want written");
    end
    clear = 1;
    tick();
    clear = 0;
    checks++;
    if ({bus.ram_addr, bus.ram_data, bus.ram_wren, bus.kb_ack, bus.out_ack, bus.busy, bus.cls_done, bus.drop_err} !== '0) begin
      errors++;
      $display("FAIL clear_mid: addr=%0d data=%h wren=%b busy=%b done=%b drop=%b, want all zero",
               bus.ram_addr, bus.ram_data, bus.ram_wren, bus.busy, bus.cls_done, bus.drop_err);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.busy || bus.cls_done || bus.ram_wren) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_mid_quiet: %0d active cycles after abort, want 0", bad);
    end
    bus.cls_start = 1;
    tick();
    bus.cls_start = 0;
    tick();
    checks++;
    if (bus.ram_wren !== 1 || bus.ram_addr !== 12'd0 || bus.ram_data !== 8'h20 || bus.busy !== 1) begin
      errors++;
      $display("FAIL clear_mid_restart: wren=%b addr=%0d data=%h busy=%b, want 1 0 20 1",
               bus.ram_wren, bus.ram_addr, bus.ram_data, bus.busy);
    end
    do_clear();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_null_char();
    test_drop();
    test_round_robin();
    test_random();
    test_sweep();
    test_clear_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/text_ram_scheduler.md
TEXT_RAM_SCHEDULER -- requirements
Module: text_ram_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports `clk` and `clear`.
REQ-002 Ports SHALL be exactly as listed (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on rising edge
- clear  in  1  synchronous active-high reset
- cls_start  in  1  request a full-screen blank sweep
- kb_req  in  1  keyboard-path write request
- kb_ascii  in  8  keyboard character
- kb_x  in  6  keyboard row
- kb_y  in  8  keyboard column
- kb_ack  out  1  one-cycle acknowledge to keyboard path
- out_req  in  1  output/replay-path write request
- out_ascii  in  8  output-path character
- out_x  in  6  output-path row
- out_y  in  8  output-path column
- out_ack  out  1  one-cycle acknowledge to output path
- ram_addr  out  12  text RAM write address
- ram_data  out  8  text RAM write data
- ram_wren  out  1  text RAM write enable
- busy  out  1  high while a sweep is in progress
- cls_done  out  1  one-cycle pulse when a sweep completes
- drop_err  out  1  sticky flag: an out-of-range write was dropped

Function
REQ-003 Constants SHALL be: ROWS=32, COLS=70, DEPTH=2240, BLANK=8'h20.
REQ-004 Address SHALL be x*70+y in 12 bits, computed exactly (x*64+x*4+x*2+y), with no truncation for in-range inputs.
REQ-005 A request SHALL be in range only when x<32 and y<70.
REQ-006 The FSM SHALL have exactly two states, IDLE and SWEEP.
REQ-007 In IDLE, cls_start=1 SHALL move the FSM to SWEEP on the next edge; no requester is granted in that cycle.
REQ-008 In SWEEP, the block SHALL write BLANK to addresses 0..2239, one per cycle, in ascending order, with ram_wren=1 on each write.
REQ-009 After writing address 2239, the FSM SHALL return to IDLE and pulse cls_done for exactly one cycle, coincident with the final write.
REQ-010 busy SHALL be 1 in every cycle in which the FSM is in SWEEP.
REQ-011 cls_start asserted during SWEEP SHALL be ignored.
REQ-012 Requests SHALL NOT be acknowledged during SWEEP; requesters stall until IDLE.
REQ-013 In IDLE without cls_start, the block SHALL grant at most one requester per cycle.
REQ-014 A requester whose ack is currently 1 SHALL be ineligible in that cycle; this prevents double-grant of a held request.
REQ-015 When both requesters are eligible and requesting, the block SHALL grant the one not granted last (round-robin); last_grant updates on every grant.
REQ-016 The grant SHALL be registered: with req sampled at edge N, the next edge SHALL drive ack=1, ram_addr, ram_data and ram_wren together for one cycle.
REQ-017 A granted request with ascii=8'h00 SHALL be acked with ram_wren=0 (discarded).
REQ-018 A granted out-of-range request SHALL be acked with ram_wren=0 and SHALL set drop_err.
REQ-019 drop_err SHALL remain 1 until clear.
REQ-020 When ram_wren=0, ram_addr and ram_data SHALL hold their previous values.
REQ-021 Requesters SHALL hold req, ascii, x and y stable until ack; the block samples them only in the grant cycle.

Reset
REQ-022 clear=1 SHALL force on the next edge: FSM=IDLE, sweep counter=0, ram_addr=0, ram_data=0, ram_wren=0, kb_ack=0, out_ack=0, busy=0, cls_done=0, drop_err=0, last_grant=out (keyboard wins the first tie).
REQ-023 clear SHALL take priority over every other input.
REQ-024 clear asserted mid-sweep SHALL abort the sweep without a cls_done pulse.

Structure
REQ-025 ROWS, COLS, DEPTH, BLANK, the address width (12) and the state encodings SHALL live in the shared text-display constants package.
REQ-026 Address computation plus range check SHALL be one sub-module, text_addr_calc (inputs x, y; outputs addr, in_range), instantiated once on the muxed request.

Verification
REQ-027 The bench SHALL cover these directed scenarios (stimulus -> required response):
- kb_req with 'A'(8'h41), x=2, y=10 -> one cycle later kb_ack=1, ram_wren=1, ram_addr=150, ram_data=8'h41.
- kb_req and out_req held together from reset -> grants alternate kb, out, kb, out; at most one wren per cycle; ack never high on consecutive cycles for the same requester.
- cls_start pulse -> busy for 2240 cycles; addresses 0..2239 written with 8'h20; cls_done on the 2240th write; a kb_req raised mid-sweep is acked only after return to IDLE.
- out_req with x=31, y=70 -> out_ack=1, ram_wren=0, drop_err=1 and stays 1; a later valid write leaves it set.
- kb_req with ascii=8'h00 -> kb_ack=1, ram_wren=0, drop_err unchanged.
- clear at sweep address 1000 -> next cycle busy=0, no cls_done, all outputs at reset values; a new cls_start restarts the sweep from address 0.
